// File: rtl/period_meter.sv
`timescale 1ns/1ps
// Reciprocal period meter: averages 2^AVG_LOG2 sig_in periods (in clk100MHz ticks) into period_out.
// Edge acted on 2 clocks after sig_in is sampled high; result 1 clock after closing edge; no backpressure.
module period_meter #(
    parameter int CNT_W    = 24,
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 10_000_000
) (
    input  logic             clk100MHz,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    localparam int                  ACC_W    = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]    TO_LIM   = CNT_W'(TIMEOUT);
    localparam logic [AVG_LOG2-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_idx;
    logic [CNT_W-1:0]    r_period;
    logic                r_vld;
    logic                r_tmo;

    logic                w_edge;
    logic                w_to_hit;
    logic [ACC_W-1:0]    w_sum;

    assign w_edge   = r_s2 & ~r_s3;
    assign w_to_hit = (r_cnt >= TO_LIM) & ~w_edge;
    assign w_sum    = r_acc + {{AVG_LOG2{1'b0}}, r_cnt};

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ARM;
                ST_ARM, ST_MEAS: begin
                    if (w_edge) begin
                        w_state_nxt = ST_MEAS;
                    end else if (w_to_hit) begin
                        w_state_nxt = ST_ARM;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        case (r_state)
            ST_ARM, ST_MEAS: busy = 1'b1;
            default:         busy = 1'b0;
        endcase
    end

    // Counter restarts at 1 whenever a count window opens so that both arming and
    // the last edge give the same distance to timeout, and N cycles between edges reads N.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_period <= '0;
            r_vld    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (!enable) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_idx <= '0;
                r_tmo <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                r_cnt <= CNT_W'(1);
                r_acc <= '0;
                r_idx <= '0;
            end else if (w_edge) begin
                r_cnt <= CNT_W'(1);
                if (r_state == ST_ARM) begin
                    r_acc <= '0;
                    r_idx <= '0;
                end else if (r_idx == IDX_LAST) begin
                    r_period <= w_sum[ACC_W-1:AVG_LOG2];
                    r_vld    <= 1'b1;
                    r_tmo    <= 1'b0;
                    r_acc    <= '0;
                    r_idx    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + AVG_LOG2'(1);
                end
            end else if (w_to_hit) begin
                r_tmo <= 1'b1;
                r_cnt <= CNT_W'(1);
                r_acc <= '0;
                r_idx <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_vld;
    assign timeout      = r_tmo;

endmodule
